// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD_DATA,
    WR_DATA
  } resp_state_t;

  localparam int SPI_RW_BIT      = 7;
  localparam int SPI_ADDR_W      = 7;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-clk rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] chain;
  logic                       prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SPI_SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SPI_SYNC_STAGES-2:0], din};
      prev  <= chain[SPI_SYNC_STAGES-1];
    end
  end

  assign sync = chain[SPI_SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave emulating a small byte register map with a chip-ID register,
// auto-incrementing read bursts and control/data write pairs.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int unsigned     NUM_REGS = 16,
  parameter logic [6:0]      ID_ADDR  = 7'h50,
  parameter logic [7:0]      ID_VALUE = 8'h58
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  input  logic                  local_we,
  input  logic [SPI_ADDR_W-1:0] local_addr,
  input  logic [7:0]            local_wdata,
  output logic                  wr_strobe,
  output logic [SPI_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  active
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic [SPI_SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .din (SCLK),
    .sync(sclk_lvl_unused),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  // SS idles high, so its synchronizer resets high to keep active low out of reset.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .din (SS),
    .sync(ss_sync),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SPI_SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sr[SPI_SYNC_STAGES-1];

  resp_state_t           state, state_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            rx_sr, rx_n, rx_shift;
  logic [7:0]            tx_sr, tx_n;
  logic [SPI_ADDR_W-1:0] addr, addr_n;
  logic                  spi_we;
  logic [7:0]            regs [NUM_REGS];

  function automatic logic [7:0] read_reg(input logic [SPI_ADDR_W-1:0] a);
    logic [7:0] r;
    r = '0;
    if (a == ID_ADDR) begin
      r = ID_VALUE;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (a == SPI_ADDR_W'(i)) r = regs[i];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr    <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx_sr   <= rx_n;
      tx_sr   <= tx_n;
      addr    <= addr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx_sr;
    tx_n      = tx_sr;
    addr_n    = addr;
    spi_we    = 1'b0;
    rx_shift  = {rx_sr[6:0], mosi_s};

    if (ss_rise) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state_n   = CMD;
            bit_cnt_n = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_n      = rx_shift;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_n    = rx_shift[SPI_ADDR_W-1:0];
              bit_cnt_n = '0;
              if (rx_shift[SPI_RW_BIT]) begin
                tx_n    = read_reg(rx_shift[SPI_ADDR_W-1:0]);
                state_n = RD_DATA;
              end else begin
                state_n = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (sclk_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_n    = addr + 1'b1;
              tx_n      = read_reg(addr + 1'b1);
              bit_cnt_n = '0;
            end
          end else if (sclk_fall && bit_cnt != 3'd0) begin
            // The fall right after a byte load is skipped so the new MSB stays put.
            tx_n = {tx_sr[6:0], 1'b0};
          end
        end
        WR_DATA: begin
          if (sclk_rise) begin
            rx_n      = rx_shift;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              spi_we    = 1'b1;
              bit_cnt_n = '0;
              state_n   = CMD;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // SPI write is applied after the local write so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (local_we && local_addr == SPI_ADDR_W'(i) && SPI_ADDR_W'(i) != ID_ADDR)
          regs[i] <= local_wdata;
        if (spi_we && addr == SPI_ADDR_W'(i) && SPI_ADDR_W'(i) != ID_ADDR)
          regs[i] <= rx_shift;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= spi_we;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= rx_shift;
      end
    end
  end

  assign MISO   = (state == RD_DATA) & tx_sr[7];
  assign active = ~ss_sync;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized scoreboard bench for spi_reg_responder against a register-map model.
module tb_spi_reg_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0, MOSI = 1'b0, SS = 1'b1;
  logic       MISO;
  logic       local_we = 1'b0;
  logic [6:0] local_addr = '0;
  logic [7:0] local_wdata = '0;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       active;

  spi_reg_responder #(.NUM_REGS(16), .ID_ADDR(7'h50), .ID_VALUE(8'h58)) dut (
    .clk        (clk),
    .rst        (rst),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .SS         (SS),
    .MISO       (MISO),
    .local_we   (local_we),
    .local_addr (local_addr),
    .local_wdata(local_wdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .active     (active)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  model_regs [16];
  logic [7:0]  exp_rd_q [$];
  logic [14:0] exp_wr_q [$];
  logic        rd_phase = 1'b0;
  logic [6:0]  col_addr;
  logic [7:0]  col_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'h50) return 8'h58;
    if (a < 7'd16)  return model_regs[a[3:0]];
    return 8'h00;
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd16) model_regs[a[3:0]] = d;
  endfunction

  // Mode 0 master: MOSI changes while SCLK is low, slave data sampled on the rise.
  task automatic spi_bits(input logic [7:0] b, input int n, input bit collide);
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      repeat (8) @(posedge clk);
      #2 SCLK = 1'b1;
      if (collide && i == 7) begin
        repeat (2) @(posedge clk);
        #1 local_we = 1'b1; local_addr = col_addr; local_wdata = col_data;
        @(posedge clk);
        #1 local_we = 1'b0;
        repeat (5) @(posedge clk);
      end else begin
        repeat (8) @(posedge clk);
      end
      #2 SCLK = 1'b0;
    end
  endtask

  task automatic spi_start();
    SS = 1'b0;
    repeat (8) @(posedge clk);
    #2 check("active_low_ss", {31'd0, active}, 32'd1);
  endtask

  task automatic spi_end();
    repeat (8) @(posedge clk);
    #2 SS = 1'b1;
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic local_write(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 local_we = 1'b1; local_addr = a; local_wdata = d;
    @(posedge clk);
    #1 local_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic read_burst(input logic [6:0] a, input int n);
    logic [6:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(model_read(p));
      p = p + 7'd1;
    end
    spi_start();
    spi_bits({1'b1, a}, 8, 1'b0);
    rd_phase = 1'b1;
    for (int i = 0; i < n; i++) spi_bits(8'($urandom), 8, 1'b0);
    rd_phase = 1'b0;
    spi_end();
  endtask

  task automatic write_pairs(input logic [6:0] a0, input logic [7:0] d0,
                             input logic [6:0] a1, input logic [7:0] d1, input int n);
    spi_start();
    for (int i = 0; i < n; i++) begin
      logic [6:0] a;
      logic [7:0] d;
      a = (i == 0) ? a0 : a1;
      d = (i == 0) ? d0 : d1;
      exp_wr_q.push_back({a, d});
      if (a != 7'h50) model_write(a, d);
      spi_bits({1'b0, a}, 8, 1'b0);
      spi_bits(d, 8, 1'b0);
    end
    spi_end();
  endtask

  task automatic write_collide(input logic [6:0] a, input logic [7:0] d,
                               input logic [6:0] la, input logic [7:0] ld);
    col_addr = la;
    col_data = ld;
    model_write(la, ld);
    model_write(a, d);
    exp_wr_q.push_back({a, d});
    spi_start();
    spi_bits({1'b0, a}, 8, 1'b0);
    spi_bits(d, 8, 1'b1);
    spi_end();
  endtask

  task automatic mon_wr();
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_wr_strobe", {25'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [14:0] e;
          e = exp_wr_q.pop_front();
          check("wr_addr", {25'd0, wr_addr}, {25'd0, e[14:8]});
          check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
        end
      end
    end
  endtask

  task automatic mon_rd();
    logic [7:0] sh;
    int         nb;
    nb = 0;
    sh = '0;
    forever begin
      @(posedge SCLK);
      if (rd_phase) begin
        sh = {sh[6:0], MISO};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_rd_q.size() == 0) check("unexpected_rd_byte", {24'd0, sh}, 32'hFFFF_FFFF);
          else check("rd_byte", {24'd0, sh}, {24'd0, exp_rd_q.pop_front()});
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    fork
      mon_wr();
      mon_rd();
    join_none

    repeat (4) @(posedge clk);
    #1;
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("idle_active", {31'd0, active}, 32'd0);

    read_burst(7'h50, 1);
    write_pairs(7'h01, 8'hA5, 7'h02, 8'h3C, 2);
    read_burst(7'h01, 2);
    local_write(7'h0F, 8'h7E);
    read_burst(7'h0F, 2);
    local_write(7'h00, 8'h11);
    read_burst(7'h7F, 2);

    // Aborted write: SS rises mid data byte.
    spi_start();
    spi_bits(8'h03, 8, 1'b0);
    spi_bits(8'hF0, 4, 1'b0);
    spi_end();
    read_burst(7'h03, 1);

    write_collide(7'h05, 8'hC3, 7'h05, 8'h99);
    write_collide(7'h06, 8'h44, 7'h07, 8'h55);
    read_burst(7'h04, 4);

    for (int t = 0; t < 24; t++) begin
      int unsigned pick, kind;
      logic [6:0] a0, a1;
      pick = $urandom_range(0, 9);
      a0 = (pick == 0) ? 7'h50 : (pick == 1) ? 7'($urandom) : 7'($urandom_range(0, 15));
      a1 = 7'($urandom_range(0, 19));
      kind = $urandom_range(0, 2);
      case (kind)
        0: write_pairs(a0, 8'($urandom), a1, 8'($urandom), int'($urandom_range(1, 2)));
        1: read_burst(a0, int'($urandom_range(1, 3)));
        default: local_write(7'($urandom_range(0, 15)), 8'($urandom));
      endcase
    end
    read_burst(7'h00, 16);

    // Reset in the middle of a write data byte.
    spi_start();
    spi_bits(8'h05, 8, 1'b0);
    spi_bits(8'hAA, 4, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_miso", {31'd0, MISO}, 32'd0);
    check("midrst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("midrst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("midrst_wr_data", {24'd0, wr_data}, 32'd0);
    check("midrst_active", {31'd0, active}, 32'd0);
    SS = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    repeat (4) @(posedge clk);
    read_burst(7'h50, 1);
    read_burst(7'h00, 6);

    repeat (20) @(posedge clk);
    #1;
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI slave register responder: the device end of the 4-wire SPI link, mode 0 (CPOL=0, CPHA=0), MSB first.
- Emulates a BMP280-style register map for bench and loopback use against the on-chip SPI master/controller.
- Protocol: command byte (bit7=1 read, bit7=0 write; bits6:0 address), followed by data bytes.
- Reads auto-increment the address. Writes are repeated control/data pairs.
- Holds a local byte register file, updatable from a fabric-side write port.

Parameters:
- NUM_REGS, 16: number of implemented byte registers, at addresses 0..NUM_REGS-1.
- ID_ADDR, 7'h50: 7-bit address of the read-only chip-ID register.
- ID_VALUE, 8'h58: constant returned when ID_ADDR is read.

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- SCLK  in  1  SPI clock from master; asynchronous to clk.
- MOSI  in  1  master-to-slave data.
- SS  in  1  slave select, active low.
- MISO  out  1  slave-to-master data.
- local_we  in  1  fabric-side register write enable.
- local_addr  in  7  fabric-side write address.
- local_wdata  in  8  fabric-side write data.
- wr_strobe  out  1  one-clk pulse per completed SPI write.
- wr_addr  out  7  address of the last SPI write.
- wr_data  out  8  data of the last SPI write.
- active  out  1  synchronized SS is low.

Behaviour:
Synchronization and edge detection
- SCLK, MOSI and SS each pass through a 2-flop synchronizer.
- Edge detect on synchronized SCLK (rise/fall) and SS (fall/rise).
- Effective latency: 3 clk from pin edge to action.

Reset
- All outputs 0. State IDLE, bit_cnt=0, shift registers 0, all registers 0.
- Reset mid-transfer aborts silently. No wr_strobe is issued.

State machine
- IDLE: MISO=0. On SS fall: bit_cnt=0, go to CMD.
- CMD:
  - Each SCLK rise shifts MOSI into rx_sr[0] and increments bit_cnt.
  - At 8th rise: addr=rx_sr[6:0], bit_cnt=0.
  - If rx_sr[7]=1: tx_sr=read(addr), go to RD_DATA.
  - Else: go to WR_DATA.
- RD_DATA:
  - MISO=tx_sr[7].
  - SCLK fall with bit_cnt in 1..7: tx_sr shifts left.
  - SCLK rise: bit_cnt++ (MOSI ignored).
  - At 8th rise: addr=addr+1 (wraps 7'h7F->7'h00), tx_sr=read(addr+1), bit_cnt=0.
  - Next MSB appears on MISO before the master's next sampling edge.
- WR_DATA:
  - Shift MOSI on rise.
  - At 8th rise: write rx byte to addr, pulse wr_strobe with wr_addr/wr_data, bit_cnt=0, return to CMD.
  - Next byte is a new control byte; there is no write auto-increment.
- Any state on SS rise: go to IDLE, partial byte discarded, no write, MISO=0.
- MISO is 0 outside RD_DATA. The bus is single-slave, so MISO is never tri-stated.

Register read
- read(a) = ID_VALUE if a==ID_ADDR.
- Otherwise reg[a] if a<NUM_REGS.
- Otherwise 8'h00.

Register write
- Writes to ID_ADDR or a>=NUM_REGS are ignored, but wr_strobe still pulses.

Write collisions
- Local write and SPI write to the same address in the same clk: SPI wins.
- Different addresses in the same clk: both take effect.
- Local writes during an active read burst become visible at the next byte load, never mid-byte.

Misc
- Command byte with SS held low and zero SCLK edges: stays in CMD indefinitely.
- active = ~SS_sync.

Decomposition:
- Shared package spi_pkg:
  - resp_state_t enum {IDLE, CMD, RD_DATA, WR_DATA}.
  - SPI_RW_BIT=7, SPI_ADDR_W=7, SPI_SYNC_STAGES=2.
- Sub-module spi_sync_edge: synchronizer plus rise/fall pulse outputs, instantiated for SCLK and SS. MOSI uses sync only.

Test Plan:
1. Reset, SS low, send 0xD0, clock 8 more bits -> MISO returns 0x58. No wr_strobe.
2. Write pairs 0x01,0xA5 then 0x02,0x3C under one SS -> two wr_strobe pulses (01/A5, 02/3C). A subsequent read burst 0x81 + 2 bytes returns A5,3C.
3. local_we addr 0x0F data 0x7E, then read burst 0x8F + 2 bytes -> 0x7E, then 0x00 (address 0x10 is out of range).
4. Read burst starting at 0xFF (addr 7'h7F) for 2 bytes, reg0=0x11 -> 0x00, 0x11 (wrap).
5. Write 0x03 then SS rises after 4 data bits -> no wr_strobe, reg3 unchanged. The next transaction decodes correctly.
6. rst asserted mid-write byte -> all outputs 0, regs 0. A post-reset read of 0xD0 returns 0x58.
